// File: rtl/alu_pkg.sv
// Shared types for the 16-bit ALU and the sequential multiply/divide controller
// that borrows it.
package alu_pkg;

  typedef enum logic [2:0] {
    ALUINST_PASS0 = 3'd0,
    ALUINST_ADDW  = 3'd1,
    ALUINST_SUBW  = 3'd2,
    ALUINST_AND   = 3'd3,
    ALUINST_OR    = 3'd4,
    ALUINST_XOR   = 3'd5,
    ALUINST_MERGE = 3'd6
  } aluinst_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    RESP = 2'd3
  } muldiv_state_t;

  localparam logic REQ_OP_MUL = 1'b0;
  localparam logic REQ_OP_DIV = 1'b1;

  localparam logic [4:0] MUL_LAST = 5'd7;
  localparam logic [4:0] DIV_LAST = 5'd15;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU shared between requesters.
// SUBW reports carry out = 1 when no borrow occurred; c_in acts as borrow-in.
module alu
  import alu_pkg::*;
(
  input  aluinst_t    inst,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  input  logic        swapop,
  input  logic        c_in,
  output logic [15:0] result,
  output logic        c_out
);

  logic [15:0] opa;
  logic [15:0] opb;
  logic [16:0] sum;

  always_comb begin
    opa    = swapop ? op1 : op0;
    opb    = swapop ? op0 : op1;
    sum    = '0;
    result = opa;
    c_out  = 1'b0;
    case (inst)
      ALUINST_PASS0: result = opa;
      ALUINST_ADDW: begin
        sum    = {1'b0, opa} + {1'b0, opb} + {16'b0, c_in};
        result = sum[15:0];
        c_out  = sum[16];
      end
      ALUINST_SUBW: begin
        sum    = {1'b0, opa} + {1'b0, ~opb} + {16'b0, ~c_in};
        result = sum[15:0];
        c_out  = sum[16];
      end
      ALUINST_AND:   result = opa & opb;
      ALUINST_OR:    result = opa | opb;
      ALUINST_XOR:   result = opa ^ opb;
      // op2 acts as a per-bit select: 1 picks opb, 0 picks opa
      ALUINST_MERGE: result = (opa & ~op2) | (opb & op2);
      default:       result = opa;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 8x8 shift-add multiplier and 16/8 restoring divider that borrows
// an external shared ALU for every add/subtract step.
//
// state | meaning
// IDLE  | ready for a request, ALU released
// MUL   | one shift-add iteration per cycle, 8 iterations
// DIV   | one restoring-subtract iteration per cycle, 16 iterations
// RESP  | result held until the consumer takes it
module muldiv_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_rem,
  output logic        rsp_divzero,
  output aluinst_t    alu_inst,
  output logic [15:0] alu_op0,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic        alu_swapop,
  output logic        alu_c_in,
  input  logic [15:0] alu_result,
  input  logic        alu_c_out
);

  muldiv_state_t state, state_nxt;

  logic [15:0] a_reg;
  logic [7:0]  b_reg;
  logic [15:0] acc;
  logic [14:0] rem;
  logic [15:0] quot;
  logic [4:0]  cnt;

  logic [15:0] mul_addend;
  logic [15:0] partial;
  logic [15:0] acc_nxt;
  logic [14:0] rem_nxt;
  logic [15:0] quot_nxt;

  // Remainder never exceeds the 8-bit divisor, so 15 stored bits are ample.
  always_comb begin
    mul_addend = {8'h00, a_reg[7:0]} << cnt[2:0];
    partial    = {rem, a_reg[4'd15 - cnt[3:0]]};
    acc_nxt    = b_reg[cnt[2:0]] ? alu_result : acc;
    rem_nxt    = alu_c_out ? alu_result[14:0] : partial[14:0];
    quot_nxt   = {quot[14:0], alu_c_out};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op == REQ_OP_MUL) state_nxt = MUL;
          else if (req_b == 8'h00)  state_nxt = RESP;
          else                      state_nxt = DIV;
        end
      end
      MUL:     if (cnt == MUL_LAST) state_nxt = RESP;
      DIV:     if (cnt == DIV_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    alu_inst   = ALUINST_PASS0;
    alu_op0    = '0;
    alu_op1    = '0;
    alu_op2    = '0;
    alu_swapop = 1'b0;
    alu_c_in   = 1'b0;
    case (state)
      MUL: begin
        alu_inst = ALUINST_ADDW;
        alu_op0  = acc;
        alu_op1  = mul_addend;
      end
      DIV: begin
        alu_inst = ALUINST_SUBW;
        alu_op0  = partial;
        alu_op1  = {8'h00, b_reg};
      end
      default: ;
    endcase
  end

  // Response registers load on the edge that enters RESP and hold there.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      rem         <= '0;
      quot        <= '0;
      cnt         <= '0;
      rsp_result  <= '0;
      rsp_rem     <= '0;
      rsp_divzero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg <= req_a;
            b_reg <= req_b;
            acc   <= '0;
            rem   <= '0;
            quot  <= '0;
            cnt   <= '0;
            if (req_op == REQ_OP_DIV && req_b == 8'h00) begin
              rsp_result  <= 16'hFFFF;
              rsp_rem     <= req_a[7:0];
              rsp_divzero <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == MUL_LAST) begin
            rsp_result  <= acc_nxt;
            rsp_rem     <= 8'h00;
            rsp_divzero <= 1'b0;
          end
        end
        DIV: begin
          rem  <= rem_nxt;
          quot <= quot_nxt;
          cnt  <= cnt + 5'd1;
          if (cnt == DIV_LAST) begin
            rsp_result  <= quot_nxt;
            rsp_rem     <= rem_nxt[7:0];
            rsp_divzero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq wired to the real alu: an arithmetic
// reference model checked every cycle, plus directed vectors with literal results.
module tb_muldiv_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [15:0] req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_rem;
  logic        rsp_divzero;
  aluinst_t    alu_inst;
  logic [15:0] alu_op0, alu_op1, alu_op2;
  logic        alu_swapop, alu_c_in;
  logic [15:0] alu_result;
  logic        alu_c_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_rem(rsp_rem), .rsp_divzero(rsp_divzero),
    .alu_inst(alu_inst), .alu_op0(alu_op0), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_swapop(alu_swapop), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_c_out(alu_c_out)
  );

  alu u_alu (
    .inst(alu_inst), .op0(alu_op0), .op1(alu_op1), .op2(alu_op2),
    .swapop(alu_swapop), .c_in(alu_c_in),
    .result(alu_result), .c_out(alu_c_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding operation, result from plain arithmetic.
  bit          armed = 1'b0;
  bit          busy = 1'b0;
  bit          rst_chk = 1'b0;
  bit          exp_v = 1'b0;
  bit          idle_now = 1'b0;
  int          due = 0;
  logic [15:0] m_res = '0;
  logic [7:0]  m_rem = '0;
  logic        m_dz = 1'b0;

  always @(negedge clk) begin
    exp_v = 1'b0;
    if (armed) begin
      if (rst_chk) begin
        check("post_reset_rsp_result", 32'(rsp_result), 32'h0);
        check("post_reset_rsp_rem", 32'(rsp_rem), 32'h0);
        check("post_reset_rsp_divzero", 32'(rsp_divzero), 32'h0);
        rst_chk = 1'b0;
      end
      exp_v = busy && (cyc + 1 >= due);
      check("model_rsp_valid", 32'(rsp_valid), 32'(exp_v));
      check("model_req_ready", 32'(req_ready), 32'(!busy));
      if (exp_v) begin
        check("model_rsp_result", 32'(rsp_result), 32'(m_res));
        check("model_rsp_rem", 32'(rsp_rem), 32'(m_rem));
        check("model_rsp_divzero", 32'(rsp_divzero), 32'(m_dz));
      end
      check("alu_op2_zero", 32'(alu_op2), 32'h0);
      check("alu_swapop_zero", 32'(alu_swapop), 32'h0);
      check("alu_c_in_zero", 32'(alu_c_in), 32'h0);
      if (!busy || exp_v) begin
        check("alu_inst_idle", 32'(alu_inst), 32'(ALUINST_PASS0));
        check("alu_op0_idle", 32'(alu_op0), 32'h0);
        check("alu_op1_idle", 32'(alu_op1), 32'h0);
      end
    end
    if (reset) begin
      busy    = 1'b0;
      rst_chk = 1'b1;
      armed   = 1'b1;
    end else if (armed) begin
      idle_now = !busy;
      if (exp_v && rsp_ready) begin
        busy = 1'b0;
      end else if (idle_now && req_valid) begin
        busy = 1'b1;
        if (req_op == 1'b0) begin
          m_res = {8'h00, req_a[7:0]} * {8'h00, req_b};
          m_rem = 8'h00;
          m_dz  = 1'b0;
          due   = cyc + 1 + 9;
        end else if (req_b == 8'h00) begin
          m_res = 16'hFFFF;
          m_rem = req_a[7:0];
          m_dz  = 1'b1;
          due   = cyc + 1 + 1;
        end else begin
          m_res = req_a / {8'h00, req_b};
          m_rem = 8'(req_a % {8'h00, req_b});
          m_dz  = 1'b0;
          due   = cyc + 1 + 17;
        end
      end
    end
  end

  task automatic run_op(input string name, input logic op, input logic [15:0] a,
                        input logic [7:0] b, input logic [15:0] e_res,
                        input logic [7:0] e_rem, input logic e_dz, input int e_lat,
                        input int hold, input int reps);
    int w;
    int t_acc;
    for (int r = 0; r < reps; r++) begin
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 40) begin @(posedge clk); #1; w++; end
      check({name, "_accept_ready"}, 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      t_acc = cyc;
      if (r == reps - 1) req_valid = 1'b0;
      w = 0;
      while (!rsp_valid && w < 40) begin @(posedge clk); #1; w++; end
      check({name, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
      check({name, "_latency"}, 32'(cyc + 1 - t_acc), 32'(e_lat));
      check({name, "_result"}, 32'(rsp_result), 32'(e_res));
      check({name, "_rem"}, 32'(rsp_rem), 32'(e_rem));
      check({name, "_divzero"}, 32'(rsp_divzero), 32'(e_dz));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check({name, "_hold_valid"}, 32'(rsp_valid), 32'h1);
        check({name, "_hold_ready"}, 32'(req_ready), 32'h0);
        check({name, "_hold_result"}, 32'(rsp_result), 32'(e_res));
        check({name, "_hold_rem"}, 32'(rsp_rem), 32'(e_rem));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({name, "_after_hs_valid"}, 32'(rsp_valid), 32'h0);
      check({name, "_after_hs_ready"}, 32'(req_ready), 32'h1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_result", 32'(rsp_result), 32'h0);
    check("reset_alu_inst", 32'(alu_inst), 32'(ALUINST_PASS0));

    run_op("mul13x11",   1'b0, 16'd13,    8'd11,  16'h008F, 8'h00, 1'b0, 9, 0, 1);
    run_op("mulFFxFF",   1'b0, 16'h00FF,  8'hFF,  16'hFE01, 8'h00, 1'b0, 9, 5, 2);
    run_op("mulx0",      1'b0, 16'h1234,  8'h00,  16'h0000, 8'h00, 1'b0, 9, 0, 1);
    run_op("mulhi",      1'b0, 16'hAB05,  8'h03,  16'h000F, 8'h00, 1'b0, 9, 1, 1);
    run_op("mul80x80",   1'b0, 16'h0080,  8'h80,  16'h4000, 8'h00, 1'b0, 9, 0, 1);
    run_op("div1000by7", 1'b1, 16'd1000,  8'd7,   16'h008E, 8'h06, 1'b0, 17, 0, 1);
    run_op("divzero",    1'b1, 16'h1234,  8'h00,  16'hFFFF, 8'h34, 1'b1, 1, 3, 2);
    run_op("divFFFFby1", 1'b1, 16'hFFFF,  8'h01,  16'hFFFF, 8'h00, 1'b0, 17, 0, 1);
    run_op("divFFFFbyFF",1'b1, 16'hFFFF,  8'hFF,  16'h0101, 8'h00, 1'b0, 17, 0, 1);
    run_op("div5by200",  1'b1, 16'd5,     8'd200, 16'h0000, 8'h05, 1'b0, 17, 0, 1);
    run_op("div50000",   1'b1, 16'd50000, 8'd123, 16'h0196, 8'h3E, 1'b0, 17, 2, 1);

    // Abort a divide with reset on the edge that ends iteration 7.
    req_op = 1'b1; req_a = 16'd1000; req_b = 8'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_rsp_result", 32'(rsp_result), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("abort_no_response", 32'(rsp_valid), 32'h0);
    end
    run_op("mul3x5", 1'b0, 16'd3, 8'd5, 16'h000F, 8'h00, 1'b0, 9, 0, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
